// File: rtl/opl3_timer_bank.sv
// OPL3 timer bank: NUM_TIMERS preloadable up-counters, each behind its own
// power-of-two prescaler. An overflow reloads the counter, optionally stops the
// timer and sets a sticky flag. The OR of the flags drives an active-low IRQ.
module opl3_timer_bank #(
  parameter int NUM_TIMERS    = 2,
  parameter int TIMER_WIDTH   = 8,
  parameter int PRESCALE_LOG2 = 2,
  parameter int PRESCALE_STEP = 2,
  parameter int SEL_W         = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_en,
  input  logic                   load_we,
  input  logic [SEL_W-1:0]       load_sel,
  input  logic [TIMER_WIDTH-1:0] load_data,
  input  logic                   ctrl_we,
  input  logic                   ctrl_irq_reset,
  input  logic [NUM_TIMERS-1:0]  ctrl_start,
  input  logic [NUM_TIMERS-1:0]  ctrl_mask,
  input  logic [NUM_TIMERS-1:0]  ctrl_oneshot,
  input  logic                   force_timer_overflow,
  output logic [NUM_TIMERS-1:0]  running,
  output logic [NUM_TIMERS-1:0]  status_flags,
  output logic                   status_irq,
  output logic                   irq_n
);

  // One spare bit keeps the prescaler at least one bit wide when timer 0 has no division.
  localparam int PW = PRESCALE_LOG2 + (NUM_TIMERS - 1) * PRESCALE_STEP + 1;
  localparam logic [TIMER_WIDTH-1:0] CNT_MAX = '1;

  logic [TIMER_WIDTH-1:0] preload_q [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] preload_d [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] counter_q [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] counter_d [NUM_TIMERS];
  logic [PW-1:0]          presc_q   [NUM_TIMERS];
  logic [PW-1:0]          presc_d   [NUM_TIMERS];
  logic [NUM_TIMERS-1:0]  mask_q, mask_d;
  logic [NUM_TIMERS-1:0]  oneshot_q, oneshot_d;
  logic [NUM_TIMERS-1:0]  running_q, running_d;
  logic [NUM_TIMERS-1:0]  flags_q, flags_d;
  logic                   irq_n_q, irq_n_d;
  logic [NUM_TIMERS-1:0]  strobe;
  logic [NUM_TIMERS-1:0]  ovf;
  logic                   start_wr;

  // All-ones terminal value of timer idx's prescaler; its division is 2^(LOG2 + idx*STEP).
  function automatic logic [PW-1:0] presc_max(input int idx);
    presc_max = PW'((64'd1 << (PRESCALE_LOG2 + idx * PRESCALE_STEP)) - 64'd1);
  endfunction

  assign start_wr = ctrl_we && !ctrl_irq_reset;

  // Next-state: prescale/count/overflow first, then ctrl writes override (start wins).
  always_comb begin
    preload_d = preload_q;
    counter_d = counter_q;
    presc_d   = presc_q;
    mask_d    = mask_q;
    oneshot_d = oneshot_q;
    running_d = running_q;
    strobe    = '0;
    ovf       = '0;
    // Clear before set so an overflow on the clearing edge is not lost.
    flags_d   = (ctrl_we && ctrl_irq_reset) ? '0 : flags_q;
    irq_n_d   = ~(|flags_q);
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (running_q[i]) begin
        if (tick_en) presc_d[i] = (presc_q[i] + 1'b1) & presc_max(i);
        strobe[i] = tick_en && ((presc_q[i] & presc_max(i)) == presc_max(i));
        ovf[i]    = force_timer_overflow || (strobe[i] && (counter_q[i] == CNT_MAX));
        if (force_timer_overflow) presc_d[i] = '0;
        if (ovf[i]) begin
          counter_d[i] = preload_q[i];
          if (oneshot_q[i]) running_d[i] = 1'b0;
          if (!mask_q[i])   flags_d[i]   = 1'b1;
        end else if (strobe[i]) begin
          counter_d[i] = counter_q[i] + 1'b1;
        end
      end
      if (start_wr) begin
        running_d[i] = ctrl_start[i];
        if (ctrl_start[i] && !running_q[i]) begin
          counter_d[i] = preload_q[i];
          presc_d[i]   = '0;
        end
      end
      if (load_we && (int'(load_sel) == i)) preload_d[i] = load_data;
    end
    if (start_wr) begin
      mask_d    = ctrl_mask;
      oneshot_d = ctrl_oneshot;
    end
  end

  // State registers; reset discards every piece of timer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      preload_q <= '{default: '0};
      counter_q <= '{default: '0};
      presc_q   <= '{default: '0};
      mask_q    <= '0;
      oneshot_q <= '0;
      running_q <= '0;
      flags_q   <= '0;
      irq_n_q   <= 1'b1;
    end else begin
      preload_q <= preload_d;
      counter_q <= counter_d;
      presc_q   <= presc_d;
      mask_q    <= mask_d;
      oneshot_q <= oneshot_d;
      running_q <= running_d;
      flags_q   <= flags_d;
      irq_n_q   <= irq_n_d;
    end
  end

  assign running      = running_q;
  assign status_flags = flags_q;
  assign status_irq   = |flags_q;
  assign irq_n        = irq_n_q;

endmodule
